// File: rtl/muxn_rr_reg_if.sv
// Handshake bundle for muxn_rr_reg: channel data/valids and controls in,
// registered selected word with its source index and select-error pulse out.
interface muxn_rr_reg_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic                        en_n;
    logic                        mode;
    logic [SELW-1:0]             sel;
    logic [CHANNELS*WIDTH-1:0]   din;
    logic [CHANNELS-1:0]         in_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            y;
    logic                        y_valid;
    logic [SELW-1:0]             y_ch;
    logic                        sel_err;

    modport master (
        output en_n, mode, sel, din, in_valid, out_ready,
        input  y, y_valid, y_ch, sel_err
    );

    modport slave (
        input  en_n, mode, sel, din, in_valid, out_ready,
        output y, y_valid, y_ch, sel_err
    );
endinterface

// File: rtl/muxn_rr_reg.sv
// N-channel registered multiplexer with manual or round-robin selection and a
// one-deep output slot that refills in the same cycle it drains.
module muxn_rr_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    muxn_rr_reg_if.slave  bus
);
    localparam int              SELW    = $clog2(CHANNELS);
    localparam logic [SELW:0]   CH_LIM  = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          y_q, y_d;
    logic [SELW-1:0]           ych_q, ych_d;
    logic [SELW-1:0]           ptr_q, ptr_d;
    logic                      sel_err_q, sel_err_d;

    logic                      sel_oor_s;
    logic [CHANNELS-1:0]       man_sh_s;
    logic [SELW:0]             pos_s;
    logic [SELW:0]             idx_w_s;
    logic [CHANNELS-1:0]       rr_sh_s;
    logic                      rr_hit_s;
    logic [SELW-1:0]           rr_idx_s;
    logic                      grant_vld_s;
    logic [SELW-1:0]           grant_idx_s;
    logic [CHANNELS*WIDTH-1:0] din_sh_s;
    logic                      slot_free_s;
    logic                      capture_s;

    // Grant evaluation and next-state computation for the output slot
    always_comb begin
        sel_oor_s = ({1'b0, bus.sel} >= CH_LIM);
        man_sh_s  = bus.in_valid >> bus.sel;
        pos_s     = '0;
        idx_w_s   = '0;
        rr_sh_s   = '0;
        rr_hit_s  = 1'b0;
        rr_idx_s  = '0;
        // Walk offsets from far to near so the nearest valid channel to ptr wins
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            pos_s    = {1'b0, ptr_q} + (SELW+1)'(k);
            idx_w_s  = (pos_s >= CH_LIM) ? (pos_s - CH_LIM) : pos_s;
            rr_sh_s  = bus.in_valid >> idx_w_s[SELW-1:0];
            rr_idx_s = rr_sh_s[0] ? idx_w_s[SELW-1:0] : rr_idx_s;
            rr_hit_s = rr_hit_s | rr_sh_s[0];
        end

        if (bus.mode) begin
            grant_vld_s = rr_hit_s;
            grant_idx_s = rr_idx_s;
        end else begin
            grant_vld_s = ~sel_oor_s & man_sh_s[0];
            grant_idx_s = bus.sel;
        end

        din_sh_s    = bus.din >> (int'(grant_idx_s) * WIDTH);
        slot_free_s = (state_q == EMPTY) | bus.out_ready;
        capture_s   = ~bus.en_n & slot_free_s & grant_vld_s;
        sel_err_d   = ~bus.mode & ~bus.en_n & sel_oor_s;

        state_d = state_q;
        y_d     = y_q;
        ych_d   = ych_q;
        ptr_d   = ptr_q;
        if (capture_s) begin
            state_d = FULL;
            y_d     = din_sh_s[WIDTH-1:0];
            ych_d   = grant_idx_s;
            if (bus.mode) begin
                ptr_d = (grant_idx_s == LAST_CH) ? '0 : (grant_idx_s + SELW'(1));
            end else begin
                ptr_d = ptr_q;
            end
        end else if (slot_free_s) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            y_q       <= '0;
            ych_q     <= '0;
            ptr_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            ych_q     <= ych_d;
            ptr_q     <= ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_ch    = ych_q;
    assign bus.y_valid = (state_q == FULL);
    assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_muxn_rr_reg.sv
// Scoreboard bench for muxn_rr_reg: a 4-channel instance for the main scenarios
// and a 3-channel instance for out-of-range select and pointer wrap.
module tb_muxn_rr_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    muxn_rr_reg_if #(.WIDTH(4), .CHANNELS(4)) bus  ();
    muxn_rr_reg_if #(.WIDTH(4), .CHANNELS(3)) bus3 ();

    muxn_rr_reg #(.WIDTH(4), .CHANNELS(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    muxn_rr_reg #(.WIDTH(4), .CHANNELS(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    task automatic test_reset();
        logic [7:0] exp_v, obs_v, obs3_v;
        for (int i = 0; i < 3; i++) begin
            rst_n         = (i == 2) ? 1'b1 : 1'b0;
            bus.en_n      = (i == 2) ? 1'b1 : 1'($urandom);
            bus.mode      = 1'($urandom);
            bus.sel       = 2'($urandom);
            bus.din       = 16'($urandom);
            bus.in_valid  = (i == 2) ? 4'b0000 : 4'($urandom);
            bus.out_ready = 1'($urandom);
            bus3.en_n      = (i == 2) ? 1'b1 : 1'($urandom);
            bus3.mode      = 1'($urandom);
            bus3.sel       = 2'($urandom);
            bus3.din       = 12'($urandom);
            bus3.in_valid  = (i == 2) ? 3'b000 : 3'($urandom);
            bus3.out_ready = 1'($urandom);
            sb_q.push_back(8'h00);
            @(posedge clk); #1;
            exp_v  = sb_q.pop_front();
            obs_v  = {bus.y, bus.y_ch, bus.y_valid, bus.sel_err};
            obs3_v = {bus3.y, bus3.y_ch, bus3.y_valid, bus3.sel_err};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL reset step %0d: y/ch/v/err got %b want %b", i, obs_v, exp_v);
            end
            n_checks++;
            if (obs3_v !== exp_v) begin
                n_errors++;
                $display("FAIL reset3 step %0d: y/ch/v/err got %b want %b", i, obs3_v, exp_v);
            end
        end
    endtask

    task automatic test_manual();
        logic [7:0] exp_v, obs_v;
        logic [1:0] sel_t [5] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
        logic [3:0] iv_t  [5] = '{4'b0100, 4'b0000, 4'b0100, 4'b0001, 4'b0000};
        logic [7:0] exp_t [5] = '{{4'hA, 2'd2, 1'b1, 1'b0}, {4'hA, 2'd2, 1'b0, 1'b0},
                                  {4'hA, 2'd2, 1'b0, 1'b0}, {4'h3, 2'd0, 1'b1, 1'b0},
                                  {4'h3, 2'd0, 1'b0, 1'b0}};
        bus.mode = 1'b0; bus.en_n = 1'b0; bus.out_ready = 1'b1; bus.din = 16'hDA63;
        for (int i = 0; i < 5; i++) begin
            bus.sel      = sel_t[i];
            bus.in_valid = iv_t[i];
            sb_q.push_back(exp_t[i]);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            obs_v = {bus.y, bus.y_ch, bus.y_valid, bus.sel_err};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL manual step %0d: y/ch/v/err got %b want %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_v, obs_v;
        logic [3:0] iv_t  [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                   4'b1010, 4'b1010, 4'b1010, 4'b0000};
        logic [7:0] exp_t [10] = '{{4'h3, 2'd0, 1'b1, 1'b0}, {4'h6, 2'd1, 1'b1, 1'b0},
                                   {4'hA, 2'd2, 1'b1, 1'b0}, {4'hD, 2'd3, 1'b1, 1'b0},
                                   {4'h3, 2'd0, 1'b1, 1'b0}, {4'h6, 2'd1, 1'b1, 1'b0},
                                   {4'hD, 2'd3, 1'b1, 1'b0}, {4'h6, 2'd1, 1'b1, 1'b0},
                                   {4'hD, 2'd3, 1'b1, 1'b0}, {4'hD, 2'd3, 1'b0, 1'b0}};
        bus.mode = 1'b1; bus.en_n = 1'b0; bus.out_ready = 1'b1; bus.din = 16'hDA63;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = iv_t[i];
            sb_q.push_back(exp_t[i]);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            obs_v = {bus.y, bus.y_ch, bus.y_valid, bus.sel_err};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL round_robin step %0d: y/ch/v/err got %b want %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_v, obs_v;
        logic       stall;
        logic [3:0] iv_t  [6] = '{4'b0001, 4'hF, 4'hF, 4'hF, 4'b1000, 4'b0000};
        logic [7:0] exp_t [6] = '{{4'h3, 2'd0, 1'b1, 1'b0}, {4'h3, 2'd0, 1'b1, 1'b0},
                                  {4'h3, 2'd0, 1'b1, 1'b0}, {4'h3, 2'd0, 1'b1, 1'b0},
                                  {4'hD, 2'd3, 1'b1, 1'b0}, {4'hD, 2'd3, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            stall         = (i >= 1) && (i <= 3);
            bus.out_ready = stall ? 1'b0 : 1'b1;
            bus.din       = stall ? 16'($urandom) : 16'hDA63;
            bus.mode      = stall ? 1'($urandom) : 1'b0;
            bus.en_n      = stall ? 1'($urandom) : 1'b0;
            bus.sel       = (i == 0) ? 2'd0 : 2'd3;
            bus.in_valid  = iv_t[i];
            sb_q.push_back(exp_t[i]);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            obs_v = {bus.y, bus.y_ch, bus.y_valid, bus.sel_err};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL backpressure step %0d: y/ch/v/err got %b want %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_disable();
        logic [7:0] exp_v, obs_v;
        logic       en_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       md_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       or_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] iv_t  [6] = '{4'hF, 4'hF, 4'b0100, 4'hF, 4'hF, 4'hF};
        logic [7:0] exp_t [6] = '{{4'hD, 2'd3, 1'b0, 1'b0}, {4'hD, 2'd3, 1'b0, 1'b0},
                                  {4'hA, 2'd2, 1'b1, 1'b0}, {4'hA, 2'd2, 1'b1, 1'b0},
                                  {4'hA, 2'd2, 1'b1, 1'b0}, {4'hA, 2'd2, 1'b0, 1'b0}};
        bus.din = 16'hDA63; bus.sel = 2'd2;
        for (int i = 0; i < 6; i++) begin
            bus.en_n      = en_t[i];
            bus.mode      = md_t[i];
            bus.out_ready = or_t[i];
            bus.in_valid  = iv_t[i];
            sb_q.push_back(exp_t[i]);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            obs_v = {bus.y, bus.y_ch, bus.y_valid, bus.sel_err};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL disable step %0d: y/ch/v/err got %b want %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_sel_err();
        logic [7:0] exp_v, obs_v;
        logic       en_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       md_t  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] sel_t [7] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [2:0] iv_t  [7] = '{3'b111, 3'b111, 3'b100, 3'b111, 3'b111, 3'b100, 3'b111};
        logic [7:0] exp_t [7] = '{{4'h0, 2'd0, 1'b0, 1'b1}, {4'h0, 2'd0, 1'b0, 1'b0},
                                  {4'h9, 2'd2, 1'b1, 1'b0}, {4'h9, 2'd2, 1'b0, 1'b1},
                                  {4'hC, 2'd0, 1'b1, 1'b0}, {4'h9, 2'd2, 1'b1, 1'b0},
                                  {4'hC, 2'd0, 1'b1, 1'b0}};
        bus3.din = 12'h95C; bus3.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus3.en_n     = en_t[i];
            bus3.mode     = md_t[i];
            bus3.sel      = sel_t[i];
            bus3.in_valid = iv_t[i];
            sb_q.push_back(exp_t[i]);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            obs_v = {bus3.y, bus3.y_ch, bus3.y_valid, bus3.sel_err};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL sel_err3 step %0d: y/ch/v/err got %b want %b", i, obs_v, exp_v);
            end
        end
        bus3.en_n = 1'b1;
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp_v, obs_v;
        logic       rst_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp_t [4] = '{{4'h3, 2'd0, 1'b1, 1'b0}, {4'h6, 2'd1, 1'b1, 1'b0},
                                  {4'h0, 2'd0, 1'b0, 1'b0}, {4'h3, 2'd0, 1'b1, 1'b0}};
        bus.mode = 1'b1; bus.en_n = 1'b0; bus.in_valid = 4'hF; bus.din = 16'hDA63;
        for (int i = 0; i < 4; i++) begin
            rst_n         = rst_t[i];
            bus.out_ready = (i == 2) ? 1'b0 : 1'b1;
            sb_q.push_back(exp_t[i]);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            obs_v = {bus.y, bus.y_ch, bus.y_valid, bus.sel_err};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL mid_reset step %0d: y/ch/v/err got %b want %b", i, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_manual();
        test_round_robin();
        test_backpressure();
        test_disable();
        test_sel_err();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
